// File: rtl/scope_filter_pkg.sv
// Shared types and reset defaults for the scope equalization filter coefficient path.
// Used by the filter datapath, the register bank and scope_filter_ctrl.
package scope_filter_pkg;

  typedef logic signed [17:0] coef_aa_t;
  typedef logic signed [24:0] coef_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_APPLY,
    ST_FLUSH,
    ST_SETTLE
  } ctrl_state_t;

  localparam coef_aa_t AA_RST_DEF = 18'h7D93;
  localparam coef_t    BB_RST_DEF = 25'h437C7;
  localparam coef_t    KK_RST_DEF = 25'hD9999A;
  localparam coef_t    PP_RST_DEF = 25'h2666;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/scope_filter_ctrl.sv
// Coefficient sequencer: shadows AA/BB/KK/PP, applies them atomically in a stream gap,
// optionally flushes the filter. Macro SCOPE_FILTER_CTRL_SETTLE_EN adds a blanked SETTLE window.
module scope_filter_ctrl
  import scope_filter_pkg::*;
#(
  parameter int unsigned RST_LEN = 4,
  parameter int unsigned SET_LEN = 64,
  parameter int unsigned TMO_LEN = 1024,
  parameter coef_aa_t    AA_RST  = AA_RST_DEF,
  parameter coef_t       BB_RST  = BB_RST_DEF,
  parameter coef_t       KK_RST  = KK_RST_DEF,
  parameter coef_t       PP_RST  = PP_RST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd_req,
  input  logic        upd_flush,
  input  logic [17:0] cfg_aa_nxt,
  input  logic [24:0] cfg_bb_nxt,
  input  logic [24:0] cfg_kk_nxt,
  input  logic [24:0] cfg_pp_nxt,
  input  logic        str_transf,
  output logic [17:0] cfg_aa,
  output logic [24:0] cfg_bb,
  output logic [24:0] cfg_kk,
  output logic [24:0] cfg_pp,
  output logic        ctl_rst,
  output logic        blank,
  output logic        busy,
  output logic        upd_ack,
  output logic [15:0] sts_ovr,
  output logic [15:0] sts_tmo
);

  // One down-counter serves WAIT, FLUSH and SETTLE, so size it for the longest.
  localparam int unsigned CNT_MAX = (TMO_LEN > RST_LEN)
                                  ? ((TMO_LEN > SET_LEN) ? TMO_LEN : SET_LEN)
                                  : ((RST_LEN > SET_LEN) ? RST_LEN : SET_LEN);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  ctrl_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             tmo_hit;
  coef_aa_t         sh_aa;
  coef_t            sh_bb, sh_kk, sh_pp;
  logic             sh_flush;
  logic             pending;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tmo_hit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (upd_req || pending) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = CNT_W'(TMO_LEN - 1);
        end
      end
      ST_WAIT: begin
        if (!str_transf) begin
          state_nxt = ST_APPLY;
        end else if (cnt == '0) begin
          state_nxt = ST_APPLY;
          tmo_hit   = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_APPLY: begin
        if (sh_flush) begin
          state_nxt = ST_FLUSH;
          cnt_nxt   = CNT_W'(RST_LEN - 1);
        end else begin
`ifdef SCOPE_FILTER_CTRL_SETTLE_EN
          state_nxt = ST_SETTLE;
          cnt_nxt   = CNT_W'(SET_LEN - 1);
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
      ST_FLUSH: begin
        if (cnt == '0) begin
`ifdef SCOPE_FILTER_CTRL_SETTLE_EN
          state_nxt = ST_SETTLE;
          cnt_nxt   = CNT_W'(SET_LEN - 1);
`else
          state_nxt = ST_IDLE;
`endif
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
`ifdef SCOPE_FILTER_CTRL_SETTLE_EN
      ST_SETTLE: begin
        if (cnt == '0) state_nxt = ST_IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Flags follow state_nxt so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_aa    <= AA_RST;
      sh_bb    <= BB_RST;
      sh_kk    <= KK_RST;
      sh_pp    <= PP_RST;
      sh_flush <= 1'b0;
      pending  <= 1'b0;
      cfg_aa   <= AA_RST;
      cfg_bb   <= BB_RST;
      cfg_kk   <= KK_RST;
      cfg_pp   <= PP_RST;
      ctl_rst  <= 1'b0;
      blank    <= 1'b0;
      busy     <= 1'b0;
      upd_ack  <= 1'b0;
      sts_ovr  <= '0;
      sts_tmo  <= '0;
    end else begin
      if (upd_req) begin
        sh_aa    <= cfg_aa_nxt;
        sh_bb    <= cfg_bb_nxt;
        sh_kk    <= cfg_kk_nxt;
        sh_pp    <= cfg_pp_nxt;
        sh_flush <= upd_flush;
      end
      if (state == ST_IDLE) begin
        pending <= 1'b0;
      end else if (upd_req) begin
        pending <= 1'b1;
        if (pending) sts_ovr <= sat_inc(sts_ovr);
      end
      if (state == ST_APPLY) begin
        cfg_aa <= sh_aa;
        cfg_bb <= sh_bb;
        cfg_kk <= sh_kk;
        cfg_pp <= sh_pp;
      end
      if (tmo_hit) sts_tmo <= sat_inc(sts_tmo);
      ctl_rst <= (state_nxt == ST_FLUSH);
`ifdef SCOPE_FILTER_CTRL_SETTLE_EN
      blank   <= (state_nxt == ST_FLUSH) || (state_nxt == ST_SETTLE);
`else
      blank   <= (state_nxt == ST_FLUSH);
`endif
      busy    <= (state_nxt != ST_IDLE);
      upd_ack <= (state != ST_IDLE) && (state_nxt == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_scope_filter_ctrl.sv
// Self-checking bench for scope_filter_ctrl: timeline model compared every cycle plus directed literal checks.
module tb_scope_filter_ctrl;

  localparam int unsigned RST_LEN = 4;
  localparam int unsigned SET_LEN = 64;
  localparam int unsigned TMO_LEN = 1024;
`ifdef SCOPE_FILTER_CTRL_SETTLE_EN
  localparam bit SETTLE_EN = 1'b1;
  localparam int EXP_BLANK = 68;
`else
  localparam bit SETTLE_EN = 1'b0;
  localparam int EXP_BLANK = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        upd_req, upd_flush, str_transf;
  logic [17:0] cfg_aa_nxt, cfg_aa;
  logic [24:0] cfg_bb_nxt, cfg_kk_nxt, cfg_pp_nxt, cfg_bb, cfg_kk, cfg_pp;
  logic        ctl_rst, blank, busy, upd_ack;
  logic [15:0] sts_ovr, sts_tmo;

  int checks = 0;
  int errors = 0;
  int ack_cnt, ctl_cnt, blank_cnt;

  scope_filter_ctrl #(
    .RST_LEN(RST_LEN),
    .SET_LEN(SET_LEN),
    .TMO_LEN(TMO_LEN)
  ) dut (
    .clk(clk), .rst(rst), .upd_req(upd_req), .upd_flush(upd_flush),
    .cfg_aa_nxt(cfg_aa_nxt), .cfg_bb_nxt(cfg_bb_nxt), .cfg_kk_nxt(cfg_kk_nxt), .cfg_pp_nxt(cfg_pp_nxt),
    .str_transf(str_transf),
    .cfg_aa(cfg_aa), .cfg_bb(cfg_bb), .cfg_kk(cfg_kk), .cfg_pp(cfg_pp),
    .ctl_rst(ctl_rst), .blank(blank), .busy(busy), .upd_ack(upd_ack),
    .sts_ovr(sts_ovr), .sts_tmo(sts_tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Model: a sequence is a timeline (wait cycles, one apply cycle, a blanked tail).
  bit          m_active, m_pend, m_sflag, m_flush_cur, m_ack, was_active;
  int          m_pos, m_apply, m_ovr, m_tmo, tail;
  logic [17:0] m_sh_aa, m_cfg_aa;
  logic [24:0] m_sh_bb, m_sh_kk, m_sh_pp, m_cfg_bb, m_cfg_kk, m_cfg_pp;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_pend = 0; m_sflag = 0; m_flush_cur = 0; m_ack = 0;
      m_pos = 0; m_apply = -1; m_ovr = 0; m_tmo = 0;
      m_sh_aa = 18'h7D93;  m_cfg_aa = 18'h7D93;
      m_sh_bb = 25'h437C7; m_cfg_bb = 25'h437C7;
      m_sh_kk = 25'hD9999A; m_cfg_kk = 25'hD9999A;
      m_sh_pp = 25'h2666;  m_cfg_pp = 25'h2666;
    end else begin
      was_active = m_active;
      m_ack = 0;
      if (!m_active) begin
        if (upd_req || m_pend) begin
          m_active = 1; m_pos = 0; m_apply = -1;
        end
      end else if (m_apply < 0) begin
        if (!str_transf || (m_pos + 1 == int'(TMO_LEN))) begin
          if (str_transf && m_tmo < 65535) m_tmo++;
          m_apply = m_pos + 1;
        end
        m_pos++;
      end else begin
        if (m_pos == m_apply) begin
          m_cfg_aa = m_sh_aa; m_cfg_bb = m_sh_bb; m_cfg_kk = m_sh_kk; m_cfg_pp = m_sh_pp;
          m_flush_cur = m_sflag;
        end
        tail = (m_flush_cur ? int'(RST_LEN) : 0) + (SETTLE_EN ? int'(SET_LEN) : 0);
        if (m_pos - m_apply == tail) begin
          m_active = 0; m_ack = 1;
        end else begin
          m_pos++;
        end
      end
      if (upd_req) begin
        m_sh_aa = cfg_aa_nxt; m_sh_bb = cfg_bb_nxt; m_sh_kk = cfg_kk_nxt; m_sh_pp = cfg_pp_nxt;
        m_sflag = upd_flush;
        if (was_active) begin
          if (m_pend && m_ovr < 65535) m_ovr++;
          m_pend = 1;
        end
      end
      if (!was_active) m_pend = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      bit e_blank, e_ctl;
      e_blank = m_active && (m_apply >= 0) && (m_pos > m_apply);
      e_ctl   = e_blank && m_flush_cur && (m_pos - m_apply <= int'(RST_LEN));
      check("cyc_cfg_aa", 32'(cfg_aa), 32'(m_cfg_aa));
      check("cyc_cfg_bb", 32'(cfg_bb), 32'(m_cfg_bb));
      check("cyc_cfg_kk", 32'(cfg_kk), 32'(m_cfg_kk));
      check("cyc_cfg_pp", 32'(cfg_pp), 32'(m_cfg_pp));
      check("cyc_busy", 32'(busy), 32'(m_active));
      check("cyc_blank", 32'(blank), 32'(e_blank));
      check("cyc_ctl_rst", 32'(ctl_rst), 32'(e_ctl));
      check("cyc_upd_ack", 32'(upd_ack), 32'(m_ack));
      check("cyc_sts_ovr", 32'(sts_ovr), 32'(m_ovr));
      check("cyc_sts_tmo", 32'(sts_tmo), 32'(m_tmo));
      if (upd_ack) ack_cnt++;
      if (ctl_rst) ctl_cnt++;
      if (blank)   blank_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [17:0] aa, input logic [24:0] bb, input logic [24:0] kk,
                     input logic [24:0] pp, input logic fl);
    upd_req = 1'b1; upd_flush = fl;
    cfg_aa_nxt = aa; cfg_bb_nxt = bb; cfg_kk_nxt = kk; cfg_pp_nxt = pp;
    tick();
    upd_req = 1'b0; upd_flush = 1'b0;
  endtask

  task automatic wait_ack(input int budget, output int n);
    n = 0;
    while (!upd_ack && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic zero_counts();
    ack_cnt = 0; ctl_cnt = 0; blank_cnt = 0;
  endtask

  task automatic check_cfg(input string name, input logic [17:0] aa, input logic [24:0] bb,
                           input logic [24:0] kk, input logic [24:0] pp);
    check({name, "_aa"}, 32'(cfg_aa), 32'(aa));
    check({name, "_bb"}, 32'(cfg_bb), 32'(bb));
    check({name, "_kk"}, 32'(cfg_kk), 32'(kk));
    check({name, "_pp"}, 32'(cfg_pp), 32'(pp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; upd_req = 1'b0; upd_flush = 1'b0; str_transf = 1'b0;
    cfg_aa_nxt = '0; cfg_bb_nxt = '0; cfg_kk_nxt = '0; cfg_pp_nxt = '0;
    zero_counts();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset state
    check_cfg("rst_cfg", 18'h7D93, 25'h437C7, 25'hD9999A, 25'h2666);
    check("rst_busy", 32'(busy), 0);
    check("rst_blank", 32'(blank), 0);
    check("rst_ctl_rst", 32'(ctl_rst), 0);
    check("rst_sts_ovr", 32'(sts_ovr), 0);
    check("rst_sts_tmo", 32'(sts_tmo), 0);
    repeat (2) tick();
    check("idle_busy", 32'(busy), 0);

    // 2: plain update, cfg visible three cycles after the request cycle
    zero_counts();
    req(18'h1ABCD, 25'h0123456, 25'h1FEDCBA, 25'h0000777, 1'b0);
    check("lat_c1_aa", 32'(cfg_aa), 32'h7D93);
    tick();
    check("lat_c2_aa", 32'(cfg_aa), 32'h7D93);
    tick();
    check_cfg("lat_c3", 18'h1ABCD, 25'h0123456, 25'h1FEDCBA, 25'h0000777);
    wait_ack(300, n);
    check("ack_delay", 32'(n), SETTLE_EN ? SET_LEN : 0);
    tick();

    // 3a: gap after 10 busy cycles
    str_transf = 1'b1;
    req(18'h00011, 25'h0000022, 25'h0000033, 25'h0000044, 1'b0);
    repeat (9) tick();
    str_transf = 1'b0;
    wait_ack(300, n);
    check("gap_ack_seen", 32'(upd_ack), 1);
    check("gap_sts_tmo", 32'(sts_tmo), 0);
    check_cfg("gap_cfg", 18'h00011, 25'h0000022, 25'h0000033, 25'h0000044);
    tick();

    // 3b: no gap for 1500 cycles -> forced apply after 1024 wait cycles
    zero_counts();
    str_transf = 1'b1;
    req(18'h2F00F, 25'h1555555, 25'h0AAAAAA, 25'h1000001, 1'b0);
    n = 0;
    while (cfg_aa != 18'h2F00F && n < 2000) begin
      tick();
      n++;
    end
    check("tmo_apply_delay", 32'(n), 1025);
    repeat (1500 - 1026) tick();
    str_transf = 1'b0;
    repeat (SET_LEN + 10) tick();
    check("tmo_sts_tmo", 32'(sts_tmo), 1);
    check("tmo_acks", 32'(ack_cnt), 1);

    // 4: flush pulse length and blanking window
    zero_counts();
    req(18'h3FFFF, 25'h1FFFFFF, 25'h0000001, 25'h1000000, 1'b1);
    repeat (2 + RST_LEN + SET_LEN + 10) tick();
    check("flush_ctl_cycles", 32'(ctl_cnt), 4);
    check("flush_blank_cycles", 32'(blank_cnt), 32'(EXP_BLANK));
    check("flush_acks", 32'(ack_cnt), 1);
    check_cfg("flush_cfg", 18'h3FFFF, 25'h1FFFFFF, 25'h0000001, 25'h1000000);

    // 5: back-to-back requests while busy, latest wins
    zero_counts();
    req(18'h00101, 25'h0000102, 25'h0000103, 25'h0000104, 1'b0);
    req(18'h00201, 25'h0000202, 25'h0000203, 25'h0000204, 1'b0);
    req(18'h00301, 25'h0000302, 25'h0000303, 25'h0000304, 1'b0);
    repeat (2 * (SET_LEN + 10) + 10) tick();
    check_cfg("ovr_cfg", 18'h00301, 25'h0000302, 25'h0000303, 25'h0000304);
    check("ovr_sts_ovr", 32'(sts_ovr), 1);
    check("ovr_acks", 32'(ack_cnt), 2);

    // 6: reset in the middle of FLUSH
    zero_counts();
    req(18'h12345, 25'h0ABCDEF, 25'h0FEDCBA, 25'h0123456, 1'b1);
    n = 0;
    while (!ctl_rst && n < 50) begin
      tick();
      n++;
    end
    check("abort_in_flush", 32'(ctl_rst), 1);
    tick();
    #2 rst = 1'b1;
    #1;
    check("abort_ctl_rst", 32'(ctl_rst), 0);
    check("abort_blank", 32'(blank), 0);
    check("abort_busy", 32'(busy), 0);
    check_cfg("abort_cfg", 18'h7D93, 25'h437C7, 25'hD9999A, 25'h2666);
    check("abort_sts_ovr", 32'(sts_ovr), 0);
    check("abort_sts_tmo", 32'(sts_tmo), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (SET_LEN + 20) tick();
    check("abort_no_ack", 32'(ack_cnt), 0);
    check_cfg("abort_cfg_after", 18'h7D93, 25'h437C7, 25'hD9999A, 25'h2666);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
